// File: rtl/sl_rx_fifo_writer_pkg.sv
// Shared definitions for the SL receive FIFO write-side front end.
package sl_rx_fifo_writer_pkg;

  localparam int SL_DATA_SIZE = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  // Width needed to count 0..n-1 (minimum 1 bit).
  function automatic int sl_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sl_rx_fifo_writer_if.sv
// Bit stream input and FIFO write port of the SL receive FIFO writer.
interface sl_rx_fifo_writer_if #(
  parameter int DATA_SIZE = 8
);

  logic                 bit_valid;
  logic                 bit_data;
  logic                 frame_err;
  logic [DATA_SIZE-1:0] fifo_wr_data;
  logic                 fifo_wr_inc;
  logic                 fifo_wr_full;

  // The writer consumes bits and drives the FIFO write port.
  modport master (
    input  bit_valid,
    input  bit_data,
    input  frame_err,
    input  fifo_wr_full,
    output fifo_wr_data,
    output fifo_wr_inc
  );

  // The environment: line decoder plus FIFO.
  modport slave (
    output bit_valid,
    output bit_data,
    output frame_err,
    output fifo_wr_full,
    input  fifo_wr_data,
    input  fifo_wr_inc
  );

endinterface

// File: rtl/sl_rx_fifo_writer_packer.sv
// Serial-to-parallel packer: shift register, bit counter and word-complete strobe.
module sl_bit_packer
  import sl_rx_fifo_writer_pkg::*;
#(
  parameter int DATA_SIZE = SL_DATA_SIZE,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 wr_clk,
  input  logic                 rd_rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  input  logic                 frame_err,
  output logic [DATA_SIZE-1:0] word_data,
  output logic                 word_done,
  output logic                 bit_cnt_nz
);

  localparam int CNT_W = sl_clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  logic [DATA_SIZE-1:0] shift_p0;
  logic [DATA_SIZE-1:0] shift_nxt;
  logic [CNT_W-1:0]     bit_cnt_p0;

  // Next shift value; the completed word includes the bit arriving this cycle.
  always_comb begin
    shift_nxt = LSB_FIRST ? {bit_data, shift_p0[DATA_SIZE-1:1]}
                          : {shift_p0[DATA_SIZE-2:0], bit_data};
    word_done = bit_valid & ~frame_err & (bit_cnt_p0 == LAST_BIT);
    word_data = shift_nxt;
    bit_cnt_nz = |bit_cnt_p0;
  end

  // Stage p0: accumulate bits; a framing error discards the partial word and any same-cycle bit.
  always_ff @(posedge wr_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      shift_p0   <= '0;
      bit_cnt_p0 <= '0;
    end else if (frame_err) begin
      shift_p0   <= '0;
      bit_cnt_p0 <= '0;
    end else if (bit_valid) begin
      shift_p0   <= shift_nxt;
      bit_cnt_p0 <= (bit_cnt_p0 == LAST_BIT) ? '0 : bit_cnt_p0 + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sl_rx_fifo_writer.sv
// SL receive FIFO writer: packs bits into words, holds one word against FIFO
// back-pressure, and counts words dropped when the hold register is occupied.
module sl_rx_fifo_writer
  import sl_rx_fifo_writer_pkg::*;
#(
  parameter int DATA_SIZE = SL_DATA_SIZE,
  parameter int CNT_SIZE  = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  wr_clk,
  input  logic                  rd_rst_n,
  sl_rx_fifo_writer_if.master   bus,
  input  logic                  ovf_clr,
  output logic [CNT_SIZE-1:0]   drop_cnt,
  output logic                  ovf_flag,
  output logic                  busy
);

  logic [DATA_SIZE-1:0] word_data;
  logic                 word_done;
  logic                 bit_cnt_nz;

  hold_state_t          state_p1;
  hold_state_t          state_nxt;
  logic [DATA_SIZE-1:0] hold_data_p1;
  logic                 push;
  logic                 load;
  logic                 drop;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (&v) ? v : v + CNT_SIZE'(1);
  endfunction

  sl_bit_packer #(
    .DATA_SIZE (DATA_SIZE),
    .LSB_FIRST (LSB_FIRST)
  ) u_packer (
    .wr_clk     (wr_clk),
    .rd_rst_n   (rd_rst_n),
    .bit_valid  (bus.bit_valid),
    .bit_data   (bus.bit_data),
    .frame_err  (bus.frame_err),
    .word_data  (word_data),
    .word_done  (word_done),
    .bit_cnt_nz (bit_cnt_nz)
  );

  // Hold FSM next state: load when empty or draining, drop when full and blocked.
  always_comb begin
    push      = (state_p1 == FULL) & ~bus.fifo_wr_full;
    load      = 1'b0;
    drop      = 1'b0;
    state_nxt = state_p1;
    case (state_p1)
      EMPTY: begin
        if (word_done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (word_done && push) begin
          load = 1'b1;
        end else if (word_done) begin
          drop = 1'b1;
        end else if (push) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Stage p1: hold FSM state register.
  always_ff @(posedge wr_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state_p1 <= EMPTY;
    else           state_p1 <= state_nxt;
  end

  // Hold register keeps its word stable until the FIFO accepts it.
  always_ff @(posedge wr_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)  hold_data_p1 <= '0;
    else if (load)  hold_data_p1 <= word_data;
  end

  // Drop accounting; a drop coinciding with a clear is counted after the clear.
  always_ff @(posedge wr_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      drop_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? CNT_SIZE'(1) : '0;
      ovf_flag <= drop;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
      ovf_flag <= 1'b1;
    end
  end

  assign bus.fifo_wr_inc  = push;
  assign bus.fifo_wr_data = hold_data_p1;
  assign busy             = (state_p1 == FULL) | bit_cnt_nz;

endmodule

// File: tb/tb_sl_rx_fifo_writer.sv
// Self-checking bench for sl_rx_fifo_writer (DATA_SIZE=8, CNT_SIZE=8, LSB first).
module tb_sl_rx_fifo_writer;

  logic       wr_clk;
  logic       rd_rst_n;
  logic       ovf_clr;
  logic [7:0] drop_cnt;
  logic       ovf_flag;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  sl_rx_fifo_writer_if #(.DATA_SIZE(8)) bus ();

  sl_rx_fifo_writer #(
    .DATA_SIZE (8),
    .CNT_SIZE  (8),
    .LSB_FIRST (1'b1)
  ) dut (
    .wr_clk   (wr_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt),
    .ovf_flag (ovf_flag),
    .busy     (busy)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // seq lists bits in transmission order, first-sent bit leftmost (seq[7]).
  typedef struct {
    logic [7:0] seq;
    int         gap;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_data  = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] seq, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(seq[i]);
      repeat (gap) tick();
    end
  endtask

  // Scoreboard: every cycle with a push must match the oldest expected word.
  always @(negedge wr_clk) begin
    if (bus.fifo_wr_inc === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_push: got data 0x%0h, expected no push", bus.fifo_wr_data);
      end else begin
        check("push_data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{seq: 8'b11110000, gap: 0, exp_word: 8'h0F};
    vecs[1] = '{seq: 8'b10101100, gap: 1, exp_word: 8'h35};
    vecs[2] = '{seq: 8'b10100101, gap: 2, exp_word: 8'hA5};
    vecs[3] = '{seq: 8'b00000001, gap: 0, exp_word: 8'h80};
    vecs[4] = '{seq: 8'b10001000, gap: 3, exp_word: 8'h11};

    rd_rst_n         = 1'b0;
    ovf_clr          = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.bit_data     = 1'b0;
    bus.frame_err    = 1'b0;
    bus.fifo_wr_full = 1'b0;
    #1;
    check("rst_wr_data", 32'(bus.fifo_wr_data), 32'h0);
    check("rst_wr_inc",  32'(bus.fifo_wr_inc),  32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_ovf_flag", 32'(ovf_flag), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    repeat (2) tick();
    rd_rst_n = 1'b1;
    tick();

    // Single word 0xA5: push one cycle after the 8th bit, for exactly one cycle.
    exp_q.push_back(8'hA5);
    send_word(8'b10100101, 0);
    check("a5_inc_k",  32'(bus.fifo_wr_inc),  32'h1);
    check("a5_data_k", 32'(bus.fifo_wr_data), 32'hA5);
    tick();
    check("a5_inc_k1", 32'(bus.fifo_wr_inc), 32'h0);
    check("a5_busy",   32'(busy),            32'h0);

    // Table of words with varied bit spacing.
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp_word);
      send_word(vecs[v].seq, vecs[v].gap);
      repeat (2) tick();
      check("tbl_busy",  32'(busy),     32'h0);
      check("tbl_drops", 32'(drop_cnt), 32'h0);
    end

    // Back-to-back words 0x01, 0x80, 0xFF.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    for (int i = 7; i >= 0; i--) begin bus.bit_valid = 1'b1; bus.bit_data = (i == 7); tick(); end
    for (int i = 7; i >= 0; i--) begin bus.bit_valid = 1'b1; bus.bit_data = (i == 0); tick(); end
    for (int i = 7; i >= 0; i--) begin bus.bit_valid = 1'b1; bus.bit_data = 1'b1;     tick(); end
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    repeat (2) tick();
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    check("b2b_drops",   32'(drop_cnt),     32'h0);

    // FIFO full: 0x11 held, 0x22 dropped, then 0x11 pushed once.
    bus.fifo_wr_full = 1'b1;
    send_word(8'b10001000, 0);
    send_word(8'b01000100, 0);
    check("full_drop_cnt", 32'(drop_cnt),          32'h1);
    check("full_ovf",      32'(ovf_flag),          32'h1);
    check("full_inc",      32'(bus.fifo_wr_inc),   32'h0);
    check("full_hold",     32'(bus.fifo_wr_data),  32'h11);
    check("full_busy",     32'(busy),              32'h1);
    exp_q.push_back(8'h11);
    bus.fifo_wr_full = 1'b0;
    tick();
    check("full_drained", 32'(exp_q.size()), 32'h0);
    check("full_busy_end", 32'(busy), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_drop_cnt", 32'(drop_cnt), 32'h0);
    check("clr_ovf",      32'(ovf_flag), 32'h0);

    // Framing error after 5 bits, with a bit in the same cycle, then 0x3C.
    repeat (5) send_bit(1'b1);
    bus.frame_err = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_data  = 1'b1;
    tick();
    bus.frame_err = 1'b0;
    bus.bit_valid = 1'b0;
    check("ferr_busy", 32'(busy), 32'h0);
    exp_q.push_back(8'h3C);
    send_word(8'b00111100, 0);
    repeat (2) tick();
    check("ferr_drained", 32'(exp_q.size()), 32'h0);

    // 300 drops saturate the counter; clear coinciding with a drop leaves 1.
    bus.fifo_wr_full = 1'b1;
    send_word(8'b11110000, 0);
    repeat (300) send_word(8'h00, 0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    check("sat_ovf",      32'(ovf_flag), 32'h1);
    repeat (7) send_bit(1'b0);
    ovf_clr = 1'b1;
    send_bit(1'b0);
    ovf_clr = 1'b0;
    check("clrdrop_cnt", 32'(drop_cnt), 32'h1);
    check("clrdrop_ovf", 32'(ovf_flag), 32'h1);
    check("sat_hold",    32'(bus.fifo_wr_data), 32'h0F);
    exp_q.push_back(8'h0F);
    bus.fifo_wr_full = 1'b0;
    tick();
    check("sat_drained", 32'(exp_q.size()), 32'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Reset with hold FULL, one drop recorded and 4 bits pending.
    bus.fifo_wr_full = 1'b1;
    send_word(8'b10101100, 0);
    send_word(8'b10100101, 0);
    repeat (4) send_bit(1'b1);
    check("prerst_busy", 32'(busy),     32'h1);
    check("prerst_drop", 32'(drop_cnt), 32'h1);
    #2;
    rd_rst_n = 1'b0;
    #1;
    check("arst_wr_data",  32'(bus.fifo_wr_data), 32'h0);
    check("arst_wr_inc",   32'(bus.fifo_wr_inc),  32'h0);
    check("arst_drop_cnt", 32'(drop_cnt),         32'h0);
    check("arst_ovf",      32'(ovf_flag),         32'h0);
    check("arst_busy",     32'(busy),             32'h0);
    bus.fifo_wr_full = 1'b0;
    tick();
    check("arst_no_push", 32'(bus.fifo_wr_inc), 32'h0);
    #2;
    rd_rst_n = 1'b1;
    exp_q.push_back(8'h0F);
    send_word(8'b11110000, 0);
    repeat (2) tick();
    check("post_rst_drained", 32'(exp_q.size()), 32'h0);
    check("post_rst_busy",    32'(busy),         32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
